aes_encrypt_core: RTL
=====================

AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 (128-bit key, 10 rounds).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to encrypt; sampled on each rising edge of clk.
REQ-006 key  input  128  cipher key, sampled only on an accepted start.
REQ-007 plaintext  input  128  input block, sampled only on an accepted start.
REQ-008 busy  output  1  high while an encryption is in progress.
REQ-009 done  output  1  single-cycle pulse when ciphertext is updated.
REQ-010 ciphertext  output  128  result block, registered.

Function
REQ-011 The block SHALL implement FIPS-197 AES-128 encryption; byte 0 of the state = bits [127:120], loaded column-major (bytes 0-3 = column 0).
REQ-012 The block SHALL have states IDLE and RUN and a 4-bit round counter rnd.
REQ-013 Accept rule: start=1 while in IDLE SHALL be accepted; at that edge the block latches state <= plaintext XOR key and round key <= key, sets rnd <= 1 and busy <= 1, and enters RUN.
REQ-014 start while in RUN SHALL be ignored, with no effect on the running operation or on the captured key or plaintext.
REQ-015 Each edge in RUN with rnd 1..9 SHALL perform these steps in order: next round key = KeyExpansion(current round key, Rcon[rnd]); then SubBytes, ShiftRows, MixColumns and AddRoundKey with the new round key; then rnd <= rnd+1.
REQ-016 At the edge in RUN with rnd=10, the block SHALL:
  - apply SubBytes, ShiftRows and AddRoundKey with round key 10 (no MixColumns);
  - write the result to ciphertext;
  - set done <= 1 and busy <= 0;
  - return to IDLE.
REQ-017 Rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10.
REQ-018 Latency: start accepted at edge E0 SHALL give done=1 and valid ciphertext in the cycle after edge E10, i.e. 10 clocks after acceptance.
REQ-019 done SHALL be high for exactly one cycle per completed encryption and low otherwise.
REQ-020 ciphertext SHALL hold its value until the next completion overwrites it; an accepted start SHALL NOT clear it.
REQ-021 Back-to-back: start=1 in the cycle where done=1 (IDLE) SHALL be accepted, giving one result every 11 cycles.
REQ-022 Changes on key or plaintext during RUN SHALL NOT affect the result.
REQ-023 Round-key expansion SHALL be on the fly, with no 11-entry key schedule storage.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, rnd=0, busy=0, done=0, ciphertext=128'h0, and clear the internal state and round-key registers to 0.
REQ-025 rst SHALL take priority over start; start with rst high SHALL be ignored.
REQ-026 rst asserted mid-RUN SHALL abort the operation: no done pulse, and ciphertext reads 0.
REQ-027 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-028 key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff -> done 10 cycles after accept, ct=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-029 key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 -> ct=3925841d02dc09fbdc118597196a0b32; internal state after round 1 = a49c7ff2689f352b6b5bea43026a5049.
REQ-030 key=0, pt=0 -> ct=66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-031 Back-to-back: the REQ-028 vector, then the REQ-030 vector started in the done cycle -> two done pulses 11 cycles apart with the correct cts; busy low only in the done cycle.
REQ-032 Start pulsed again at round 5 with a different key and plaintext -> ignored, ct matches the first vector.
REQ-033 rst asserted at round 6 -> busy=0, done never pulses, ciphertext=0; a new start then yields the correct ct.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// -----------------------------------------------------------------------------
// aes_encrypt_core
//   Iterative AES-128 encryption engine. Each encryption does one round per
//   clock. The round key is expanded on the fly from the previous round key,
//   so no key schedule is stored. An accepted start loads the initial
//   AddRoundKey. Rounds 1..9 run on the next nine edges. Round 10, the final
//   round without MixColumns, runs on the tenth edge and writes ciphertext.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset (priority over start)
//   start       encryption request, accepted only while idle
//   key         128-bit cipher key, captured on an accepted start
//   plaintext   128-bit input block, captured on an accepted start
//   busy        high while an encryption is in progress
//   done        one-cycle pulse when ciphertext has just been updated
//   ciphertext  registered result, held until the next completion
//
// Byte order: byte 0 of the AES state is bits [127:120]. Bytes fill the
// state column by column (bytes 0-3 form column 0).
// -----------------------------------------------------------------------------
module aes_encrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x starts at bit 8*(255-x). For an 8-bit x, 255-x equals ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubBytes and ShiftRows together.
  // Row r of output column c comes from row r of input column (c+r) mod 4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      o[127 - 32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return o;
  endfunction

  // One step of AES-128 key expansion. The temp word is
  // SubWord(RotWord(w3)) XOR {rc, 24'h0}.
  function automatic logic [127:0] key_expand(input logic [127:0] rk,
                                              input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = rk;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e         r_fsm;
  state_e         w_fsm_next;
  logic   [3:0]   r_rnd;
  logic   [127:0] r_state;
  logic   [127:0] r_rkey;
  logic   [127:0] r_ct;
  logic           r_done;

  logic           w_accept;
  logic           w_step;
  logic           w_last;
  logic   [127:0] w_rkey_next;
  logic   [127:0] w_sub_shift;
  logic   [127:0] w_round_out;

  // Next-state logic. In IDLE a start is accepted. In RUN every edge
  // performs one round, and the round with rnd=10 is the last.
  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_step     = 1'b0;
    w_last     = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_fsm_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_rnd == 4'd10) begin
          w_last     = 1'b1;
          w_fsm_next = ST_IDLE;
        end
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then sees the pre-edge values of the others, with no ordering races.
    if (rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // Round datapath. The round key is expanded from the current round key
  // in the same cycle it is used. The final round skips MixColumns.
  assign w_rkey_next = key_expand(r_rkey, rcon(r_rnd));
  assign w_sub_shift = sub_shift(r_state);
  assign w_round_out = (w_last ? w_sub_shift : mix_columns(w_sub_shift)) ^ w_rkey_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd   <= 4'd0;
      r_state <= '0;
      r_rkey  <= '0;
      r_ct    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        // Initial AddRoundKey with the cipher key itself.
        r_state <= plaintext ^ key;
        r_rkey  <= key;
        r_rnd   <= 4'd1;
      end else if (w_step) begin
        r_state <= w_round_out;
        r_rkey  <= w_rkey_next;
        if (w_last) begin
          r_ct  <= w_round_out;
          r_rnd <= 4'd0;
        end else begin
          r_rnd <= r_rnd + 4'd1;
        end
      end
    end
  end

  assign busy       = (r_fsm == ST_RUN);
  assign done       = r_done;
  assign ciphertext = r_ct;

endmodule
